seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller, double-buffered hex frame
// Optional leading-zero blanking enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic                  LOAD,
    input  logic [DIGITS-1:0]     EN_MASK,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME_DONE
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_pend;
    logic [4*DIGITS-1:0]   r_shadow;
    logic                  r_pend_vld;
    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     r_an;
    logic                  r_frame_done;

    logic                  w_wrap;
    logic                  w_last;
    logic [3:0]            w_nib;
    logic [DIGITS-1:0]     w_lz_blank;
    logic [6:0]            w_seg_nxt;
    logic [DIGITS-1:0]     w_an_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign w_wrap = (r_cnt == CW'(CLK_DIV - 1));
    assign w_last = (r_idx == IW'(DIGITS - 1));

    always_comb begin
        w_nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib = r_shadow[i*4 +: 4];
            end
        end
    end

`ifdef SEG_LZB_EN
    logic w_upper_zero;

    // A digit is blanked when it and every digit to its left are zero.
    always_comb begin
        w_lz_blank   = '0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_upper_zero  = w_upper_zero && (r_shadow[i*4 +: 4] == 4'h0);
            w_lz_blank[i] = w_upper_zero;
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_seg_nxt   = 7'h7F;
        w_an_nxt    = '1;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CW'(BLANK_CYC - 1)) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_wrap) begin
                    w_state_nxt = ST_BLANK;
                end
                for (int i = 0; i < DIGITS; i++) begin
                    if (r_idx == IW'(i) && EN_MASK[i] && !w_lz_blank[i]) begin
                        w_an_nxt[i] = 1'b0;
                        w_seg_nxt   = f_decode(w_nib);
                    end
                end
            end
            default: w_state_nxt = ST_BLANK;
        endcase
    end

    // Shadow swaps in the cycle FRAME_DONE is high; digit 0 is still in its
    // blank gap then, so no digit ever sees a half-updated frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_shadow     <= '0;
            r_pend_vld   <= 1'b0;
            r_seg        <= 7'h7F;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_wrap ? '0 : r_cnt + 1'b1;
            r_frame_done <= w_wrap && w_last;
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
            if (w_wrap) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
            if (r_frame_done) begin
                r_pend_vld <= 1'b0;
                if (LOAD) begin
                    r_pend   <= DATA;
                    r_shadow <= DATA;
                end else if (r_pend_vld) begin
                    r_shadow <= r_pend;
                end
            end else if (LOAD) begin
                r_pend     <= DATA;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign SEG        = r_seg;
    assign AN         = r_an;
    assign FRAME_DONE = r_frame_done;

endmodule
